pic_priority_unit: RTL and testbench
====================================

# pic_priority_unit

Parametrised interrupt priority unit for the PIC datapath: holds the request (IRR) and in-service (ISR) registers and resolves priority over NUM_IRQ channels. Adds edge/level capture, fixed or rotating priority, special mask mode, and EOI handling. Runs the two-pulse INTA acknowledge handshake itself. Sits between the IR input pins and the control logic that drives INT and places the vector on the data bus.

## Interface
- NUM_IRQ, 8, number of request channels (2..32)
- IDW, $clog2(NUM_IRQ), channel index width (derived, not overridden)

- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- irq_in  in  NUM_IRQ  raw request lines, already synchronised
- level_mode  in  1  1: level-triggered; 0: rising-edge-triggered
- imr  in  NUM_IRQ  interrupt mask, 1 = masked
- special_mask_en  in  1  special mask mode: masked ISR bits do not block
- auto_rotate  in  1  non-specific EOI rotates priority
- eoi_valid  in  1  one-cycle EOI command strobe
- eoi_specific  in  1  1: specific EOI on eoi_level
- eoi_rotate  in  1  specific EOI also sets eoi_level lowest priority
- eoi_level  in  IDW  target channel for specific EOI
- set_prio_valid  in  1  set lowest-priority channel without EOI
- set_prio_level  in  IDW  new lowest-priority channel
- inta  in  1  one-cycle strobe per acknowledge pulse
- int_out  out  1  interrupt request to CPU
- vector_valid  out  1  one-cycle strobe, vector_id valid
- vector_id  out  IDW  acknowledged channel
- irr  out  NUM_IRQ  request register
- isr  out  NUM_IRQ  in-service register
- lowest_prio  out  IDW  current lowest-priority channel

## Operation
- Priority order:
  - Highest priority is channel (lowest_prio+1) mod NUM_IRQ, descending cyclically.
  - Reset lowest_prio = NUM_IRQ-1, so IR0 is highest.
- IRR capture:
  - Edge mode: bit sets on irq_in & ~irq_q and holds until granted.
  - Level mode: bit follows irq_in.
  - IRR is not updated in ACK1_WAIT; grant clearing still applies.
- Candidates: irr & ~imr.
- Blocking set:
  - Blocking set is isr, or isr & ~imr when special_mask_en.
  - The highest-priority blocking bit blocks itself and every lower-priority channel.
- Winner: the highest-priority candidate strictly above the blocking level.
- FSM states:
  - IDLE: go to PEND when a winner exists.
  - PEND: int_out=1. If the winner vanishes, return to IDLE. On inta, enter ACK1_WAIT.
    - With a winner: latch cur_id, set isr[cur_id], clear irr[cur_id].
    - Without a winner: spurious; cur_id=NUM_IRQ-1, no ISR change.
  - ACK1_WAIT: int_out=0. On inta, pulse vector_valid with vector_id=cur_id, go to IDLE.
- inta in IDLE is ignored.
- EOI:
  - Non-specific: clears the highest-priority set ISR bit, ignoring special_mask_en. If auto_rotate, lowest_prio := that bit. No effect if ISR is empty.
  - Specific: clears isr[eoi_level]. If eoi_rotate, lowest_prio := eoi_level.
- set_prio_valid: lowest_prio := set_prio_level.
- Simultaneous events:
  - EOI clear and ACK set on the same ISR bit in the same cycle: set wins.
  - EOI rotate and set_prio in the same cycle: EOI rotate wins.
  - Resolution always uses register values from before the edge.

## Timing
- Reset values: irr, isr, irq_q = 0; lowest_prio = NUM_IRQ-1; state IDLE; int_out, vector_valid, vector_id = 0.
- Reset mid-handshake returns to IDLE with no vector pulse.
- Edge sampled at clock k: irr set after k, int_out=1 after k+1.
- First inta sampled at k: ISR updated and int_out=0 after k.
- Second inta sampled at m: vector_valid=1 for exactly the cycle after m.
- vector_id holds cur_id until the next grant.
- EOI, rotation and set_prio take effect one edge after the strobe.
- A newly unblocked request can raise int_out one edge after the EOI.

## Configuration
- PIC_AUTO_EOI_EN:
  - Defined: on the second inta, isr[cur_id] clears in the same edge as the vector_valid set. If auto_rotate, lowest_prio := cur_id.
  - Undefined: ISR clears only via eoi_valid.

## Structure
- pic_pkg:
  - FSM state enum (IDLE, PEND, ACK1_WAIT).
  - Helper function for idx-to-onehot.
- Sub-module pic_priority_resolve_n, purely combinational, parameter NUM_IRQ:
  - Inputs: candidates, blocking set, lowest_prio.
  - Outputs: winner valid, winner index, highest in-service index.
  - Rotate, find-first and unrotate happen inside it.

## Test plan
- Edge mode, irq_in=0x28, reset priority -> int_out after 2 cycles; two inta -> vector_id=3, isr=0x08, irr=0x20; no int_out for IR5 until non-specific EOI, then IR5 acknowledged.
- auto_rotate=1, service IR2 then non-specific EOI -> lowest_prio=2; irq 0x09 -> IR3 wins over IR0.
- Level mode, irq_in=0x10 dropped between PEND and inta -> spurious: vector_id=7, isr unchanged.
- isr=0x02, imr=0x02, special_mask_en=1, irq IR5 -> IR5 acknowledged; with special_mask_en=0 -> int_out stays 0.
- Specific EOI on level 2 with eoi_rotate=1 in the same cycle as set_prio_level=6 -> isr[2]=0, lowest_prio=2; reset asserted in ACK1_WAIT -> all registers at reset values, no vector_valid.
- With PIC_AUTO_EOI_EN, one full ack of IR1 -> isr=0 after the second inta.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC priority unit.
// Optional feature macro used by the unit: PIC_AUTO_EOI_EN.
package pic_pkg;

  // Widest channel count the unit supports.
  localparam int MAX_IRQ = 32;

  // Acknowledge handshake states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PEND      = 2'd1,
    ACK1_WAIT = 2'd2
  } pic_state_e;

  // Channel index to one-hot; callers narrow the result to NUM_IRQ bits.
  function automatic logic [MAX_IRQ-1:0] idx2onehot(input logic [4:0] idx);
    logic [MAX_IRQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/pic_priority_resolve_n.sv
// Combinational priority resolver. Walks channels from highest priority
// ((lowest_prio+1) mod NUM_IRQ) downward, so the rotate / find-first /
// unrotate steps collapse into one cyclic scan.
module pic_priority_resolve_n #(
  parameter int NUM_IRQ = 8,
  localparam int IDW = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] cand,
  input  logic [NUM_IRQ-1:0] blk,
  input  logic [NUM_IRQ-1:0] isr,
  input  logic [IDW-1:0]     lowest_prio,
  output logic               win_valid,
  output logic [IDW-1:0]     win_idx,
  output logic               hi_valid,
  output logic [IDW-1:0]     hi_idx
);

  // Cyclic scan: the first blocking bit shuts out itself and everything below.
  always_comb begin
    logic           blk_found;
    logic [IDW-1:0] kk;
    int             k;
    win_valid = 1'b0;
    win_idx   = '0;
    hi_valid  = 1'b0;
    hi_idx    = '0;
    blk_found = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      k  = (int'(lowest_prio) + 1 + i) % NUM_IRQ;
      kk = IDW'(k);
      if (blk[kk]) blk_found = 1'b1;
      if (!blk_found && !win_valid && cand[kk]) begin
        win_valid = 1'b1;
        win_idx   = kk;
      end
      if (!hi_valid && isr[kk]) begin
        hi_valid = 1'b1;
        hi_idx   = kk;
      end
    end
  end

endmodule

// File: rtl/pic_priority_unit.sv
// PIC interrupt priority unit: IRR/ISR registers, edge/level capture,
// fixed or rotating priority, special mask mode, EOI and the two-pulse
// INTA handshake. Optional macro PIC_AUTO_EOI_EN clears the in-service
// bit on the second INTA.
// Handshake: inta is a one-cycle strobe per pulse; the first pulse in PEND
// grants, the second in ACK1_WAIT produces a one-cycle vector_valid.
module pic_priority_unit
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  localparam int IDW = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               level_mode,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               special_mask_en,
  input  logic               auto_rotate,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic               eoi_rotate,
  input  logic [IDW-1:0]     eoi_level,
  input  logic               set_prio_valid,
  input  logic [IDW-1:0]     set_prio_level,
  input  logic               inta,
  output logic               int_out,
  output logic               vector_valid,
  output logic [IDW-1:0]     vector_id,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [IDW-1:0]     lowest_prio
);

  pic_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [IDW-1:0]     lowest_q, lowest_d;
  logic [IDW-1:0]     cur_id_q, cur_id_d;
  logic               int_out_q, int_out_d;
  logic               vv_q, vv_d;
  logic [IDW-1:0]     vid_q, vid_d;
`ifdef PIC_AUTO_EOI_EN
  // Set when the latched cur_id is a real grant, not a spurious one.
  logic               cur_real_q, cur_real_d;
`endif

  logic [NUM_IRQ-1:0] cand, blk;
  logic               win_valid, hi_valid;
  logic [IDW-1:0]     win_idx, hi_idx;
  logic               eoi_rot_valid;
  logic [IDW-1:0]     eoi_rot_idx;

  // Special mask mode lets masked in-service channels stop blocking.
  always_comb begin
    cand = irr_q & ~imr;
    blk  = special_mask_en ? (isr_q & ~imr) : isr_q;
  end

  pic_priority_resolve_n #(.NUM_IRQ(NUM_IRQ)) u_resolve (
    .cand        (cand),
    .blk         (blk),
    .isr         (isr_q),
    .lowest_prio (lowest_q),
    .win_valid   (win_valid),
    .win_idx     (win_idx),
    .hi_valid    (hi_valid),
    .hi_idx      (hi_idx)
  );

  // Next-state: capture, EOI clear, FSM grant/ack, then priority updates.
  always_comb begin
    state_d   = state_q;
    irq_d     = irq_in;
    isr_d     = isr_q;
    lowest_d  = lowest_q;
    cur_id_d  = cur_id_q;
    vv_d      = 1'b0;
    vid_d     = vid_q;
`ifdef PIC_AUTO_EOI_EN
    cur_real_d = cur_real_q;
`endif

    // IRR freezes while waiting for the second acknowledge pulse.
    if (state_q == ACK1_WAIT) irr_d = irr_q;
    else if (level_mode)      irr_d = irq_in;
    else                      irr_d = irr_q | (irq_in & ~irq_q);

    // EOI clears first so a same-cycle grant on that bit wins.
    eoi_rot_valid = 1'b0;
    eoi_rot_idx   = '0;
    if (eoi_valid) begin
      if (eoi_specific) begin
        isr_d = isr_d & ~NUM_IRQ'(idx2onehot(5'(eoi_level)));
        if (eoi_rotate) begin
          eoi_rot_valid = 1'b1;
          eoi_rot_idx   = eoi_level;
        end
      end else if (hi_valid) begin
        isr_d = isr_d & ~NUM_IRQ'(idx2onehot(5'(hi_idx)));
        if (auto_rotate) begin
          eoi_rot_valid = 1'b1;
          eoi_rot_idx   = hi_idx;
        end
      end
    end

    if (set_prio_valid) lowest_d = set_prio_level;

    case (state_q)
      IDLE: begin
        if (win_valid) state_d = PEND;
      end
      PEND: begin
        if (inta) begin
          state_d = ACK1_WAIT;
          if (win_valid) begin
            cur_id_d = win_idx;
            isr_d    = isr_d | NUM_IRQ'(idx2onehot(5'(win_idx)));
            irr_d    = irr_d & ~NUM_IRQ'(idx2onehot(5'(win_idx)));
          end else begin
            cur_id_d = IDW'(NUM_IRQ - 1);
          end
`ifdef PIC_AUTO_EOI_EN
          cur_real_d = win_valid;
`endif
        end else if (!win_valid) begin
          state_d = IDLE;
        end
      end
      ACK1_WAIT: begin
        if (inta) begin
          state_d = IDLE;
          vv_d    = 1'b1;
          vid_d   = cur_id_q;
`ifdef PIC_AUTO_EOI_EN
          if (cur_real_q) begin
            isr_d = isr_d & ~NUM_IRQ'(idx2onehot(5'(cur_id_q)));
            if (auto_rotate) lowest_d = cur_id_q;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (eoi_rot_valid) lowest_d = eoi_rot_idx;

    int_out_d = (state_d == PEND);
  end

  // State and register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      irr_q     <= '0;
      isr_q     <= '0;
      lowest_q  <= IDW'(NUM_IRQ - 1);
      cur_id_q  <= '0;
      int_out_q <= 1'b0;
      vv_q      <= 1'b0;
      vid_q     <= '0;
`ifdef PIC_AUTO_EOI_EN
      cur_real_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      lowest_q  <= lowest_d;
      cur_id_q  <= cur_id_d;
      int_out_q <= int_out_d;
      vv_q      <= vv_d;
      vid_q     <= vid_d;
`ifdef PIC_AUTO_EOI_EN
      cur_real_q <= cur_real_d;
`endif
    end
  end

  assign int_out      = int_out_q;
  assign vector_valid = vv_q;
  assign vector_id    = vid_q;
  assign irr          = irr_q;
  assign isr          = isr_q;
  assign lowest_prio  = lowest_q;

endmodule

// File: tb/tb_pic_priority_unit.sv
// Self-checking bench for pic_priority_unit (NUM_IRQ = 8).
module tb_pic_priority_unit;

  localparam int NUM_IRQ = 8;
  localparam int IDW     = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_IRQ-1:0] irq_in = '0;
  logic               level_mode = 1'b0;
  logic [NUM_IRQ-1:0] imr = '0;
  logic               special_mask_en = 1'b0;
  logic               auto_rotate = 1'b0;
  logic               eoi_valid = 1'b0;
  logic               eoi_specific = 1'b0;
  logic               eoi_rotate = 1'b0;
  logic [IDW-1:0]     eoi_level = '0;
  logic               set_prio_valid = 1'b0;
  logic [IDW-1:0]     set_prio_level = '0;
  logic               inta = 1'b0;
  logic               int_out;
  logic               vector_valid;
  logic [IDW-1:0]     vector_id;
  logic [NUM_IRQ-1:0] irr;
  logic [NUM_IRQ-1:0] isr;
  logic [IDW-1:0]     lowest_prio;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  pic_priority_unit #(.NUM_IRQ(NUM_IRQ)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .irq_in          (irq_in),
    .level_mode      (level_mode),
    .imr             (imr),
    .special_mask_en (special_mask_en),
    .auto_rotate     (auto_rotate),
    .eoi_valid       (eoi_valid),
    .eoi_specific    (eoi_specific),
    .eoi_rotate      (eoi_rotate),
    .eoi_level       (eoi_level),
    .set_prio_valid  (set_prio_valid),
    .set_prio_level  (set_prio_level),
    .inta            (inta),
    .int_out         (int_out),
    .vector_valid    (vector_valid),
    .vector_id       (vector_id),
    .irr             (irr),
    .isr             (isr),
    .lowest_prio     (lowest_prio)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic raise_irq(input logic [NUM_IRQ-1:0] v);
    irq_in = '0;
    step();
    irq_in = v;
    step();
    step();
  endtask

  task automatic ack(input int id);
    inta = 1'b1;
    step();
    inta = 1'b0;
    check_eq("ack1_int_low", 32'(int_out), 0);
    step();
    exp_q.push_back(32'(id));
    inta = 1'b1;
    step();
    inta = 1'b0;
    check_eq("vv_pulse", 32'(vector_valid), 1);
    step();
    check_eq("vv_one_cycle", 32'(vector_valid), 0);
    check_eq("vec_id_hold", 32'(vector_id), 32'(id));
  endtask

  task automatic eoi_ns();
    eoi_valid    = 1'b1;
    eoi_specific = 1'b0;
    step();
    eoi_valid    = 1'b0;
  endtask

  task automatic eoi_sp(input int lvl, input logic rot);
    eoi_valid    = 1'b1;
    eoi_specific = 1'b1;
    eoi_rotate   = rot;
    eoi_level    = IDW'(lvl);
    step();
    eoi_valid    = 1'b0;
    eoi_specific = 1'b0;
    eoi_rotate   = 1'b0;
  endtask

  // Scoreboard: every vector pulse must match the oldest expected channel.
  always @(negedge clk) begin
    if (vector_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("vec_spurious_pulse", 32'(vector_valid), 0);
      end else begin
        exp_v = exp_q.pop_front();
        check_eq("vec_id", 32'(vector_id), exp_v);
      end
    end
  end

  initial begin
    int ch;
    logic [NUM_IRQ-1:0] exp_isr;

    // Reset
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check_eq("rst_int_out", 32'(int_out), 0);
    check_eq("rst_irr", 32'(irr), 0);
    check_eq("rst_isr", 32'(isr), 0);
    check_eq("rst_lowest", 32'(lowest_prio), 7);
    check_eq("rst_vid", 32'(vector_id), 0);
    check_eq("rst_vv", 32'(vector_valid), 0);

`ifndef PIC_AUTO_EOI_EN
    // Edge mode, IR3 and IR5 together; IR3 wins, IR5 waits for EOI
    irq_in = 8'h28;
    step();
    check_eq("t1_irr", 32'(irr), 32'h28);
    check_eq("t1_int_early", 32'(int_out), 0);
    step();
    check_eq("t1_int", 32'(int_out), 1);
    ack(3);
    check_eq("t1_isr", 32'(isr), 32'h08);
    check_eq("t1_irr_after", 32'(irr), 32'h20);
    repeat (3) step();
    check_eq("t1_ir5_blocked", 32'(int_out), 0);
    eoi_ns();
    check_eq("t1_isr_eoi", 32'(isr), 0);
    step();
    check_eq("t1_ir5_int", 32'(int_out), 1);
    ack(5);
    check_eq("t1_isr5", 32'(isr), 32'h20);
    eoi_ns();
    check_eq("t1_isr_clear", 32'(isr), 0);

    // Rotating priority via non-specific EOI
    auto_rotate = 1'b1;
    raise_irq(8'h04);
    check_eq("t2_int", 32'(int_out), 1);
    ack(2);
    eoi_ns();
    check_eq("t2_lowest", 32'(lowest_prio), 2);
    irq_in = 8'h09;
    step();
    check_eq("t2_irr", 32'(irr), 32'h09);
    step();
    ack(3);
    check_eq("t2_isr", 32'(isr), 32'h08);
    eoi_ns();
    check_eq("t2_lowest3", 32'(lowest_prio), 3);
    step();
    ack(0);
    eoi_ns();
    check_eq("t2_lowest0", 32'(lowest_prio), 0);
    auto_rotate    = 1'b0;
    set_prio_valid = 1'b1;
    set_prio_level = 3'd7;
    step();
    set_prio_valid = 1'b0;
    check_eq("t2_set_prio", 32'(lowest_prio), 7);

    // Level mode request dropped before INTA: spurious vector 7
    irq_in = '0;
    step();
    level_mode = 1'b1;
    irq_in = 8'h10;
    step();
    check_eq("t3_irr", 32'(irr), 32'h10);
    step();
    check_eq("t3_int", 32'(int_out), 1);
    irq_in = '0;
    step();
    ack(7);
    check_eq("t3_isr", 32'(isr), 0);
    level_mode = 1'b0;

    // Special mask mode
    raise_irq(8'h02);
    ack(1);
    check_eq("t4_isr1", 32'(isr), 32'h02);
    imr = 8'h02;
    special_mask_en = 1'b1;
    irq_in = 8'h22;
    step();
    check_eq("t4_irr", 32'(irr), 32'h20);
    step();
    check_eq("t4_int_smm", 32'(int_out), 1);
    ack(5);
    check_eq("t4_isr", 32'(isr), 32'h22);
    eoi_sp(5, 1'b0);
    check_eq("t4_isr_sp", 32'(isr), 32'h02);
    special_mask_en = 1'b0;
    irq_in = 8'h02;
    step();
    irq_in = 8'h22;
    step();
    step();
    step();
    check_eq("t4_int_blocked", 32'(int_out), 0);
    special_mask_en = 1'b1;
    step();
    check_eq("t4_int_unblocked", 32'(int_out), 1);
    ack(5);
    eoi_sp(5, 1'b0);
    eoi_sp(1, 1'b0);
    check_eq("t4_isr_clear", 32'(isr), 0);
    imr = '0;
    special_mask_en = 1'b0;

    // Specific EOI rotate beats same-cycle set_prio
    raise_irq(8'h04);
    ack(2);
    check_eq("t5_isr", 32'(isr), 32'h04);
    eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_rotate = 1'b1; eoi_level = 3'd2;
    set_prio_valid = 1'b1; set_prio_level = 3'd6;
    step();
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; set_prio_valid = 1'b0;
    check_eq("t5_isr_clr", 32'(isr), 0);
    check_eq("t5_lowest", 32'(lowest_prio), 2);
`endif

    // Reset during ACK1_WAIT
    raise_irq(8'h40);
    check_eq("t6_int", 32'(int_out), 1);
    inta = 1'b1;
    step();
    inta = 1'b0;
`ifndef PIC_AUTO_EOI_EN
    check_eq("t6_isr", 32'(isr), 32'h40);
`endif
    rst_n = 1'b0;
    step();
    check_eq("t6_irr", 32'(irr), 0);
    check_eq("t6_isr_rst", 32'(isr), 0);
    check_eq("t6_lowest", 32'(lowest_prio), 7);
    check_eq("t6_vid", 32'(vector_id), 0);
    check_eq("t6_int_rst", 32'(int_out), 0);
    irq_in = '0;
    rst_n = 1'b1;
    step();
    inta = 1'b1;
    step();
    inta = 1'b0;
    step();
    check_eq("t6_vv_idle", 32'(vector_valid), 0);
    check_eq("t6_int_idle", 32'(int_out), 0);

`ifdef PIC_AUTO_EOI_EN
    raise_irq(8'h02);
    ack(1);
    check_eq("t7_auto_eoi_isr", 32'(isr), 0);
`endif

    // Random single-channel requests at reset priority
    for (int n = 0; n < 8; n++) begin
      ch = $urandom_range(0, NUM_IRQ - 1);
      raise_irq(NUM_IRQ'(1) << ch);
      check_eq("rnd_int", 32'(int_out), 1);
      ack(ch);
`ifdef PIC_AUTO_EOI_EN
      exp_isr = '0;
`else
      exp_isr = NUM_IRQ'(1) << ch;
`endif
      check_eq("rnd_isr", 32'(isr), 32'(exp_isr));
      eoi_ns();
      check_eq("rnd_isr_eoi", 32'(isr), 0);
    end

    step();
    check_eq("sb_drain", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
